// File: rtl/sa_ram_rwsp_clr_param.sv
// sa_ram_rwsp_clr_param: parametrised 1R1W synchronous RAM with post-reset zero clear, optional output register and address range check
module sa_ram_rwsp_clr_param #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 514,
  parameter int AW = 8,
  parameter int OUT_REG = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             init_done,
  output logic             oor_err,
  input  logic [31:0]      pwrbus_ram_pd
);
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [AW:0] lim = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] last = AW'(DEPTH - 1);
  state_t state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d, ra_q, ra_d, w_addr;
  logic v1_q, v1_d, oor_q, oor_d, vld_q, vld_d;
  logic [WIDTH-1:0] dout_q, dout_d, rdata, w_data;
  logic [WIDTH-1:0] mem [DEPTH];
  logic ready, w_ok, r_ok, w_en;
  logic unused;
  assign unused = ^pwrbus_ram_pd;
  assign ready = state_q == READY;
  assign rdata = ({1'b0, ra_q} < lim) ? mem[ra_q] : '0;
  always_comb begin
    state_d = (state_q == CLEAR && clr_cnt_q == last) ? READY : state_q;
    clr_cnt_d = (state_q == CLEAR && clr_cnt_q != last) ? clr_cnt_q + 1'b1 : clr_cnt_q;
    w_ok = {1'b0, wa} < lim;
    r_ok = {1'b0, ra} < lim;
    w_en = ready ? we && w_ok : 1'b1;
    w_addr = ready ? wa : clr_cnt_q;
    w_data = ready ? di : '0;
    ra_d = (ready && re) ? ra : ra_q;
    v1_d = ready && re;
    oor_d = oor_q | (ready && ((we && !w_ok) || (re && !r_ok)));
    dout_d = (ready && ore) ? rdata : dout_q;
    vld_d = (ready && ore) ? v1_q : vld_q;
  end
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
      ra_q <= '0;
      v1_q <= 1'b0;
      oor_q <= 1'b0;
      dout_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ra_q <= ra_d;
      v1_q <= v1_d;
      oor_q <= oor_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
    end
  end
  assign dout = (OUT_REG != 0) ? dout_q : (ready ? rdata : '0);
  assign dout_vld = (OUT_REG != 0) ? vld_q : v1_q;
  assign init_done = ready;
  assign oor_err = oor_q;
endmodule

// File: tb/tb_sa_ram_rwsp_clr_param.sv
// tb_sa_ram_rwsp_clr_param: randomized bench with a behavioural RAM model for both output-register modes
module tb_sa_ram_rwsp_clr_param;
  localparam int DEPTH = 160;
  localparam int WIDTH = 514;
  localparam int AW = 8;
  logic clk = 1'b0, rstn = 1'b0;
  logic [AW-1:0] ra = '0, wa = '0;
  logic re = 1'b0, ore = 1'b0, we = 1'b0;
  logic [WIDTH-1:0] di = '0;
  logic [31:0] pd;
  logic [WIDTH-1:0] dout1, dout0;
  logic vld1, vld0, init1, init0, oor1, oor0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sa_ram_rwsp_clr_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
    .wa(wa), .we(we), .di(di), .init_done(init1), .oor_err(oor1), .pwrbus_ram_pd(pd));
  sa_ram_rwsp_clr_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
    .wa(wa), .we(we), .di(di), .init_done(init0), .oor_err(oor0), .pwrbus_ram_pd(pd));
  logic [WIDTH-1:0] m [DEPTH];
  logic [WIDTH-1:0] m_dout;
  logic [AW-1:0] m_rd;
  int m_cnt;
  bit m_ready, m_v1, m_vld, m_oor;
  function automatic logic [WIDTH-1:0] rv(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? m[a] : '0;
  endfunction
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0;
      m_ready = 0;
      m_v1 = 0;
      m_vld = 0;
      m_oor = 0;
      m_rd = '0;
      m_dout = '0;
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1;
    end else begin
      if (ore) begin
        m_dout = rv(m_rd);
        m_vld = m_v1;
      end
      if (we) begin
        if (int'(wa) < DEPTH) m[wa] = di;
        else m_oor = 1;
      end
      if (re) begin
        m_rd = ra;
        m_v1 = 1;
        if (int'(ra) >= DEPTH) m_oor = 1;
      end else m_v1 = 0;
    end
  end
  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rstn) begin
      chk("init_done1", WIDTH'(init1), WIDTH'(m_ready));
      chk("init_done0", WIDTH'(init0), WIDTH'(m_ready));
      chk("oor_err1", WIDTH'(oor1), WIDTH'(m_oor));
      chk("oor_err0", WIDTH'(oor0), WIDTH'(m_oor));
      chk("dout_vld1", WIDTH'(vld1), WIDTH'(m_vld));
      chk("dout1", dout1, m_dout);
      chk("dout_vld0", WIDTH'(vld0), WIDTH'(m_v1));
      if (m_v1) chk("dout0", dout0, rv(m_rd));
    end
  end
  function automatic logic [WIDTH-1:0] rnd_data();
    logic [WIDTH-1:0] v = '0;
    for (int i = 0; i < WIDTH; i += 32) v = (v << 32) | WIDTH'($urandom);
    return v;
  endfunction
  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom % 16 == 0) ? AW'($urandom_range(255, DEPTH)) : AW'($urandom_range(DEPTH - 1, 0));
  endfunction
  task automatic wait_init(input int exp);
    int k = 0;
    while (!init1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("init latency", WIDTH'(k), WIDTH'(exp));
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rstn = 1'b0; we = 1'b0; re = 1'b0; ore = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst dout1", dout1, '0);
    chk("rst vld1", WIDTH'(vld1), '0);
    chk("rst oor1", WIDTH'(oor1), '0);
    #1 rstn = 1'b1;
    wait_init(DEPTH);
  endtask
  task automatic write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    #1 we = 1'b1; wa = a; di = d;
    @(negedge clk);
    #1 we = 1'b0;
  endtask
  task automatic read_lit(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    @(negedge clk);
    #1 re = 1'b1; ra = a; ore = 1'b0;
    @(negedge clk);
    chk("lit dout0", dout0, exp);
    chk("lit vld0", WIDTH'(vld0), WIDTH'(1));
    #1 re = 1'b0; ore = 1'b1;
    @(negedge clk);
    chk("lit dout1", dout1, exp);
    chk("lit vld1", WIDTH'(vld1), WIDTH'(1));
    #1 ore = 1'b0;
  endtask
  initial begin
    pd = $urandom;
    repeat (3) @(negedge clk);
    chk("reset init", WIDTH'(init1), '0);
    chk("reset dout1", dout1, '0);
    chk("reset vld1", WIDTH'(vld1), '0);
    chk("reset vld0", WIDTH'(vld0), '0);
    chk("reset oor", WIDTH'(oor1), '0);
    #1 rstn = 1'b1;
    wait_init(DEPTH);
    read_lit(0, '0);
    read_lit(80, '0);
    read_lit(159, '0);
    write(7, WIDTH'(12'h15A));
    read_lit(7, WIDTH'(12'h15A));
    @(negedge clk);
    #1 we = 1'b1; wa = 3; di = WIDTH'(8'hAA); re = 1'b1; ra = 3; ore = 1'b0;
    @(negedge clk);
    chk("same-cycle dout0", dout0, WIDTH'(8'hAA));
    #1 we = 1'b1; wa = 3; di = WIDTH'(8'hBB); re = 1'b0; ore = 1'b1;
    @(negedge clk);
    chk("late-write dout1", dout1, WIDTH'(8'hAA));
    #1 we = 1'b0; ore = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      #1 we = 1'($urandom); wa = rnd_addr(); di = rnd_data();
      re = 1'($urandom); ra = ($urandom % 4 == 0) ? wa : rnd_addr(); ore = ($urandom % 4 != 0);
    end
    @(negedge clk);
    #1 we = 1'b0; re = 1'b0; ore = 1'b0;
    do_reset();
    write(7, WIDTH'(12'h15A));
    @(negedge clk);
    #1 re = 1'b1; ra = 7; ore = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("ore hold dout1", dout1, '0);
      chk("ore hold vld1", WIDTH'(vld1), '0);
    end
    #1 ore = 1'b1;
    @(negedge clk);
    chk("ore edge dout1", dout1, WIDTH'(12'h15A));
    chk("ore edge vld1", WIDTH'(vld1), WIDTH'(1));
    #1 ore = 1'b0; re = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ore off dout1", dout1, WIDTH'(12'h15A));
      chk("ore off vld1", WIDTH'(vld1), WIDTH'(1));
    end
    chk("oor before", WIDTH'(oor1), '0);
    write(200, rnd_data());
    chk("oor write", WIDTH'(oor1), WIDTH'(1));
    read_lit(200, '0);
    read_lit(7, WIDTH'(12'h15A));
    repeat (4) @(negedge clk);
    chk("oor sticky", WIDTH'(oor0), WIDTH'(1));
    @(negedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b1; we = 1'b1; wa = 5; di = rnd_data(); re = 1'b1; ra = 5; ore = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("clear vld1", WIDTH'(vld1), '0);
      chk("clear vld0", WIDTH'(vld0), '0);
      chk("clear dout1", dout1, '0);
      #1 ra = AW'($urandom_range(DEPTH - 1, 0));
    end
    #1 rstn = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b1;
    wait_init(DEPTH);
    #1 we = 1'b0; re = 1'b0; ore = 1'b0;
    read_lit(5, '0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
